// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types, defaults and the x -> 2x+1 recurrence of the arithmetic pipeline.
package pipe_pkg;
  localparam int W_DEFAULT = 4;
  typedef struct packed {
    logic                 tag;
    logic [W_DEFAULT-1:0] data;
  } entry_t;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_t;
  function automatic logic [W_DEFAULT-1:0] next_val(input logic [W_DEFAULT-1:0] x);
    return W_DEFAULT'({x, 1'b1});
  endfunction
endpackage

// File: rtl/pipe_sink_fifo.sv
// pipe_sink_fifo: buffer of {data,tag} entries with occupancy tracking and full/valid flags.
module pipe_sink_fifo import pipe_pkg::*; #(
  parameter int W = W_DEFAULT,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [W:0]     wr_data,
  input  logic           rd_en,
  input  logic           clear,
  output logic [W:0]     rd_data,
  output logic           full,
  output logic           valid,
  output logic [PTR_W:0] count
);
  logic [W:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count_nxt;
  occ_t             state, state_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= OCC_EMPTY;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) begin
          mem[wr_ptr] <= wr_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      state <= state_nxt;
    end
  end
  // occupancy state tracks count so full/valid come straight from a register
  always_comb begin
    count_nxt = clear ? '0 : count + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
    state_nxt = (count_nxt == '0) ? OCC_EMPTY :
                (count_nxt == (PTR_W+1)'(DEPTH)) ? OCC_FULL : OCC_PARTIAL;
  end
  assign full    = (state == OCC_FULL);
  assign valid   = (state != OCC_EMPTY);
  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/pipe_retire_sink.sv
// pipe_retire_sink: pipeline endpoint that buffers retired values and checks the 2x+1 recurrence.
module pipe_retire_sink import pipe_pkg::*; #(
  parameter int W = W_DEFAULT,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  input  logic           in_tag,
  output logic           stall_out,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_tag,
  input  logic           out_ready,
  input  logic           flush,
  output logic           seq_err,
  output logic [PTR_W:0] count
);
  logic         acc, pop, have_prev;
  logic [W-1:0] prev, expect_val;
  logic [W:0]   head;
  assign acc        = in_valid & ~stall_out & ~flush;
  assign pop        = out_valid & out_ready & ~flush;
  assign expect_val = W'({prev, 1'b1});
  assign out_data   = head[W:1];
  assign out_tag    = head[0];
  pipe_sink_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (acc),
    .wr_data ({in_data, in_tag}),
    .rd_en   (pop),
    .clear   (flush),
    .rd_data (head),
    .full    (stall_out),
    .valid   (out_valid),
    .count   (count)
  );
  // seq_err is sticky across flush; only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_err   <= 1'b0;
      have_prev <= 1'b0;
      prev      <= '0;
    end else if (flush) begin
      have_prev <= 1'b0;
    end else if (acc) begin
      if (have_prev && in_data != expect_val) seq_err <= 1'b1;
      prev      <= in_data;
      have_prev <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_retire_sink.sv
// tb_pipe_retire_sink: scoreboard-driven bench for the retire sink buffer and recurrence checker.
module tb_pipe_retire_sink;
  localparam int W = 4;
  localparam int DEPTH = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_tag = 1'b0;
  logic         stall_out, out_valid, out_tag, seq_err;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   count;
  logic [W:0]   q [$];
  logic         m_have = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_prev = '0, m_exp;
  int           tests_run = 0, failed = 0;
  pipe_retire_sink #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_tag(in_tag),
    .stall_out(stall_out), .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .out_ready(out_ready), .flush(flush), .seq_err(seq_err), .count(count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    bit a, p;
    a = in_valid && q.size() < DEPTH && !flush;
    p = q.size() > 0 && out_ready && !flush;
    if (a) begin
      m_exp = m_prev * 2 + 1;
      if (m_have && in_data != m_exp) m_err = 1'b1;
      m_prev = in_data;
      m_have = 1'b1;
    end
    if (flush) begin
      q.delete();
      m_have = 1'b0;
    end else begin
      if (p) void'(q.pop_front());
      if (a) q.push_back({in_tag, in_data});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_flush();
    in_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
  endtask
  task automatic test_reset();
    tests_run++;
    if ({count, out_valid, stall_out, seq_err, out_data, out_tag} !== '0) begin
      failed++;
      $display("FAIL reset: count=%0d valid=%b stall=%b err=%b data=%h tag=%b, want all zero",
               count, out_valid, stall_out, seq_err, out_data, out_tag);
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask
  task automatic test_stream();
    logic [W-1:0] vals [4] = '{4'd1, 4'd3, 4'd7, 4'd15};
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = vals[i]; tick();
      tests_run++;
      if (!out_valid || out_data !== vals[i] || stall_out !== 1'b0 || seq_err !== 1'b0) begin
        failed++;
        $display("FAIL stream[%0d]: valid=%b data=%0d stall=%b err=%b, want 1 %0d 0 0",
                 i, out_valid, out_data, stall_out, seq_err, vals[i]);
      end
    end
    in_valid = 1'b0; tick();
  endtask
  task automatic test_backpressure();
    logic [W-1:0] vals [5] = '{4'd1, 4'd3, 4'd7, 4'd15, 4'd15};
    int n;
    do_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = vals[i]; tick();
      tests_run++;
      if (count !== 3'(q.size()) || stall_out !== (q.size() == DEPTH)) begin
        failed++;
        $display("FAIL fill[%0d]: count=%0d stall=%b, want %0d %b", i, count, stall_out, q.size(), q.size() == DEPTH);
      end
    end
    in_data = vals[4]; tick(); tick();
    tests_run++;
    if (count !== 3'd4 || stall_out !== 1'b1 || out_data !== 4'd1) begin
      failed++;
      $display("FAIL full_hold: count=%0d stall=%b head=%0d, want 4 1 1", count, stall_out, out_data);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    tests_run++;
    if (count !== 3'd3 || stall_out !== 1'b0 || out_data !== 4'd3) begin
      failed++;
      $display("FAIL one_pop: count=%0d stall=%b head=%0d, want 3 0 3", count, stall_out, out_data);
    end
    tick(); in_valid = 1'b0;
    tests_run++;
    if (count !== 3'd4 || stall_out !== 1'b1) begin
      failed++;
      $display("FAIL fifth_accept: count=%0d stall=%b, want 4 1", count, stall_out);
    end
    out_ready = 1'b1; n = 0;
    while (q.size() > 0 && n < 8) begin
      tests_run++;
      if (!out_valid || out_data !== q[0][W-1:0]) begin
        failed++;
        $display("FAIL drain[%0d]: valid=%b data=%0d, want 1 %0d", n, out_valid, out_data, q[0][W-1:0]);
      end
      tick(); n++;
    end
    tests_run++;
    if (out_valid !== 1'b0 || count !== 3'd0 || seq_err !== m_err) begin
      failed++;
      $display("FAIL drained: valid=%b count=%0d err=%b, want 0 0 %b", out_valid, count, seq_err, m_err);
    end
  endtask
  task automatic test_flush();
    do_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 4'd1; tick(); in_data = 4'd3; tick(); in_data = 4'd7; tick();
    in_data = 4'd9; flush = 1'b1; tick(); flush = 1'b0;
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL flush: count=%0d valid=%b, want 0 0", count, out_valid);
    end
    in_data = 4'd5; tick(); in_data = 4'd11; tick(); in_valid = 1'b0;
    tests_run++;
    if (count !== 3'd2 || out_data !== 4'd5 || seq_err !== 1'b0 || m_err !== 1'b0) begin
      failed++;
      $display("FAIL flush_seed: count=%0d head=%0d err=%b, want 2 5 0", count, out_data, seq_err);
    end
  endtask
  task automatic test_tag();
    logic [W-1:0] vals [4] = '{4'd1, 4'd3, 4'd7, 4'd15};
    int n;
    do_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = vals[i]; in_tag = (vals[i] == 4'd7); tick();
    end
    in_valid = 1'b0; in_tag = 1'b0; out_ready = 1'b1; n = 0;
    while (q.size() > 0 && n < 8) begin
      tests_run++;
      if (out_data !== q[0][W-1:0] || out_tag !== q[0][W] || out_tag !== (out_data == 4'd7)) begin
        failed++;
        $display("FAIL tag[%0d]: data=%0d tag=%b, want %0d %b", n, out_data, out_tag, q[0][W-1:0], q[0][W]);
      end
      tick(); n++;
    end
  endtask
  task automatic test_seq_err();
    do_flush();
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 4'd1; tick();
    tests_run++;
    if (seq_err !== 1'b0) begin
      failed++;
      $display("FAIL seq_seed: err=%b, want 0", seq_err);
    end
    in_data = 4'd4; tick();
    tests_run++;
    if (seq_err !== 1'b1 || m_err !== 1'b1) begin
      failed++;
      $display("FAIL seq_bad: err=%b, want 1", seq_err);
    end
    in_data = 4'd9; tick(); in_data = 4'd3; tick(); in_valid = 1'b0;
    do_flush();
    tests_run++;
    if (seq_err !== 1'b1) begin
      failed++;
      $display("FAIL seq_sticky: err=%b, want 1", seq_err);
    end
  endtask
  task automatic test_wrap();
    do_flush();
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 4'd15; tick(); tick(); tick(); in_valid = 1'b0; tick();
    tests_run++;
    if (seq_err !== m_err || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL wrap: err=%b valid=%b, want %b 0", seq_err, out_valid, m_err);
    end
  endtask
  task automatic test_async_reset();
    do_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 4'd1; tick(); in_data = 4'd3; tick(); in_data = 4'd7; tick(); in_valid = 1'b0;
    tests_run++;
    if (count !== 3'd3) begin
      failed++;
      $display("FAIL pre_rst: count=%0d, want 3", count);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0 || stall_out !== 1'b0 || seq_err !== 1'b0) begin
      failed++;
      $display("FAIL async_rst: count=%0d valid=%b stall=%b err=%b, want 0 0 0 0", count, out_valid, stall_out, seq_err);
    end
    q.delete(); m_have = 1'b0; m_err = 1'b0; m_prev = '0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 4'd6; tick(); in_valid = 1'b0;
    tests_run++;
    if (count !== 3'd1 || out_data !== 4'd6 || seq_err !== 1'b0) begin
      failed++;
      $display("FAIL post_rst: count=%0d head=%0d err=%b, want 1 6 0", count, out_data, seq_err);
    end
  endtask
  initial begin
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_tag();
    test_seq_err();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
